// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU types and helpers for the nibble-serial adder
package alu_pkg;

  localparam int NIB_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Nibble counter width; a single-nibble adder still needs one counter bit.
  function automatic int cnt_width(input int nib);
    return (nib <= 1) ? 1 : $clog2(nib);
  endfunction

endpackage

// File: rtl/nibble_adder4.sv
// rtl/nibble_adder4.sv - combinational 4-bit ripple adder with carry into the top bit
module nibble_adder4
  import alu_pkg::*;
(
  input  logic [NIB_W-1:0] a,
  input  logic [NIB_W-1:0] b,
  input  logic             cin,
  output logic [NIB_W-1:0] sum,
  output logic             cout,
  output logic             c_msb
);

  logic [NIB_W:0] c;

  always_comb begin
    c    = '0;
    sum  = '0;
    c[0] = cin;
    for (int i = 0; i < NIB_W; i++) begin
      sum[i]  = a[i] ^ b[i] ^ c[i];
      c[i+1]  = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign cout  = c[NIB_W];
  assign c_msb = c[NIB_W-1];

endmodule

// File: rtl/nibble_serial_adder.sv
// rtl/nibble_serial_adder.sv - multi-cycle adder, one nibble per clock, LSB first
// Optional subtract mode when NIBBLE_SERIAL_ADDER_SUB_EN is defined.
module nibble_serial_adder
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
)
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int NIB   = WIDTH / NIB_W;
  localparam int CNT_W = cnt_width(NIB);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NIB - 1);

  if ((WIDTH % NIB_W) != 0 || WIDTH < NIB_W) begin : g_width_check
    $error("nibble_serial_adder: WIDTH must be a positive multiple of 4");
  end

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic             carry;
  logic [CNT_W+1:0] bit_ix;
  logic [NIB_W-1:0] nib_sum;
  logic             nib_cout;
  logic             nib_cmsb;
  logic [WIDTH-1:0] b_load;
  logic             c_load;
  logic             cout_fin;

  assign bit_ix = {cnt, 2'b00};

  nibble_adder4 u_nib (
    .a     (a_r[bit_ix +: NIB_W]),
    .b     (b_r[bit_ix +: NIB_W]),
    .cin   (carry),
    .sum   (nib_sum),
    .cout  (nib_cout),
    .c_msb (nib_cmsb)
  );

`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
  logic sub_r;

  // a - b - cin == a + ~b + ~cin; the final carry is then the inverse of borrow.
  always_comb begin
    b_load   = sub ? ~b : b;
    c_load   = sub ? ~cin : cin;
    cout_fin = sub_r ? ~nib_cout : nib_cout;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      sub_r <= 1'b0;
    else if ((state == IDLE || state == DONE) && start)
      sub_r <= sub;
  end
`else
  always_comb begin
    b_load   = b;
    c_load   = cin;
    cout_fin = nib_cout;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      a_r      <= '0;
      b_r      <= '0;
      carry    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      sum      <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            a_r   <= a;
            b_r   <= b_load;
            carry <= c_load;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          sum[bit_ix +: NIB_W] <= nib_sum;
          carry                <= nib_cout;
          if (cnt == LAST) begin
            cout     <= cout_fin;
            overflow <= nib_cmsb ^ nib_cout;
            busy     <= 1'b0;
            done     <= 1'b1;
            state    <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
